// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with a strobe/ack access port, per-byte write enables,
// selectable read-during-write data and a clear engine that fills memory with INIT_VAL.
module ram_sp_be #(
  parameter int          DW         = 32,
  parameter int          DEPTH      = 16,
  parameter int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int          WR_FIRST   = 1,
  parameter int          CLR_ON_RST = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      adr,
  input  logic [DW-1:0]      dat_w,
  input  logic [DW/8-1:0]    sel,
  input  logic               we,
  input  logic               stb,
  output logic               ack,
  output logic [DW-1:0]      dat_r,
  input  logic               clr,
  output logic               busy
);

  localparam int NB = DW / 8;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACK} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   dat_r_q, dat_r_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            in_rng;
  logic [DW-1:0]   old_w;
  logic [DW-1:0]   merged_w;
  logic            mem_we;
  logic [AW-1:0]   mem_adr;
  logic [DW-1:0]   mem_wd;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [NB-1:0] lanes);
    logic [DW-1:0] m;
    m = old_v;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) m[8*i +: 8] = new_v[8*i +: 8];
    end
    return m;
  endfunction

  // Addresses past the last word read as zero and never write.
  assign in_rng   = (32'(adr) < 32'(DEPTH));
  assign old_w    = in_rng ? mem_q[adr] : '0;
  assign merged_w = merge_lanes(old_w, dat_w, sel);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dat_r_d = dat_r_q;
    mem_we  = 1'b0;
    mem_adr = adr;
    mem_wd  = merged_w;
    case (state_q)
      S_CLEAR: begin
        mem_we  = 1'b1;
        mem_adr = ptr_q;
        mem_wd  = INIT_VAL;
        if (ptr_q == AW'(DEPTH - 1)) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
        end else if (stb) begin
          state_d = S_ACK;
          mem_we  = we && in_rng;
          if (!in_rng)                    dat_r_d = '0;
          else if (we && (WR_FIRST != 0)) dat_r_d = merged_w;
          else                            dat_r_d = old_w;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      ptr_q   <= '0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dat_r_q <= dat_r_d;
    end
  end

  // Storage has no reset; a write is dropped only in a cycle where rst is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_adr] <= mem_wd;
  end

  assign ack   = (state_q == S_ACK);
  assign busy  = (state_q == S_CLEAR);
  assign dat_r = dat_r_q;

endmodule
